// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver
// Plays buffered J/K commands into a downstream JK flip-flop. Each command
// holds its J/K pair for cmd_len+1 cycles, and commands run back to back.
// A cycle-accurate model of the flip-flop runs alongside and is compared
// against the flip-flop's q. Divergences are flagged and counted.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on FIFO occupancy and is
// never a function of cmd_valid. While cmd_valid is high and cmd_ready is
// low, the presented command is simply not taken.
module jk_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_j,
    input  logic             cmd_k,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    output logic             busy,
    input  logic             q,
    input  logic             chk_en,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
);

    // Pointer width. DEPTH is a power of two, so the pointers wrap naturally.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // FIFO entry layout: {j, k, len}.
    localparam int EW = LEN_W + 2;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;
    logic             head_j;
    logic             head_k;
    logic [LEN_W-1:0] head_len;

    // FSM state
    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             need_cmd;

    // Expected-q model of the downstream flip-flop
    logic             exp_q;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    // Full blocks a push even when a pop happens on the same edge.
    // This keeps cmd_ready a pure function of the occupancy.
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;

    // The FSM wants a new command when idle, or on the last cycle of the
    // current one. Loading on that last edge removes any gap between
    // consecutive commands.
    assign need_cmd  = (state == IDLE) || (remaining == '0);
    assign pop       = need_cmd && !empty;

    assign head      = mem[rd_ptr];
    assign head_j    = head[EW-1];
    assign head_k    = head[EW-2];
    assign head_len  = head[LEN_W-1:0];

    assign busy      = (state == DRIVE);

    // Storage write. It needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_j, cmd_k, cmd_len};
        end
    end

    // Write and read pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy. A push and a pop on the same edge leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drive FSM: j/k and the hold counter are registered together with state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            j         <= 1'b0;
            k         <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        j         <= head_j;
                        k         <= head_k;
                        remaining <= head_len;
                        state     <= DRIVE;
                    end else begin
                        j <= 1'b0;
                        k <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (remaining != '0) begin
                        remaining <= remaining - LEN_W'(1);
                    end else if (!empty) begin
                        j         <= head_j;
                        k         <= head_k;
                        remaining <= head_len;
                    end else begin
                        j     <= 1'b0;
                        k     <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    j     <= 1'b0;
                    k     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Expected-q model: same edge and the same J/K semantics as the flip-flop
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   exp_q <= 1'b1;
                2'b01:   exp_q <= 1'b0;
                2'b11:   exp_q <= !exp_q;
                default: exp_q <= exp_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Checker: registered mismatch pulse and a saturating error count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            mismatch <= chk_en && (q != exp_q);
            if (chk_en && (q != exp_q) && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Testbench for jk_cmd_driver. A behavioural JK flip-flop closes the loop
// on q. q can be forced to the opposite value to create divergences. A
// second instance with a 2-bit error counter covers saturation.
module tb_jk_cmd_driver;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_j;
    logic       cmd_k;
    logic [3:0] cmd_len;
    logic       j;
    logic       k;
    logic       busy;
    logic       q;
    logic       chk_en;
    logic       mismatch;
    logic [7:0] err_count;

    // outputs of the narrow-counter instance
    logic       cmd_ready2;
    logic       j2;
    logic       k2;
    logic       busy2;
    logic       mismatch2;
    logic [1:0] err_count2;

    logic       q_ff;
    logic       q_force;

    int checks;
    int failures;

    logic [1:0] exp_jk_q[$];

    typedef struct {
        logic       v;
        logic       cj;
        logic       ck;
        logic [3:0] len;
        logic       ej;
        logic       ek;
        logic       ebusy;
        logic       eready;
    } vec_t;

    vec_t vecs[15];

    jk_cmd_driver #(.DEPTH(4), .LEN_W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_j     (cmd_j),
        .cmd_k     (cmd_k),
        .cmd_len   (cmd_len),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .q         (q),
        .chk_en    (chk_en),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    jk_cmd_driver #(.DEPTH(4), .LEN_W(4), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready2),
        .cmd_j     (cmd_j),
        .cmd_k     (cmd_k),
        .cmd_len   (cmd_len),
        .j         (j2),
        .k         (k2),
        .busy      (busy2),
        .q         (q),
        .chk_en    (chk_en),
        .mismatch  (mismatch2),
        .err_count (err_count2)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural downstream JK flip-flop that shares rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_ff <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   q_ff <= 1'b1;
                2'b01:   q_ff <= 1'b0;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    assign q = q_force ? ~q_ff : q_ff;

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic cj, input logic ck, input logic [3:0] len);
        cmd_valid = 1'b1;
        cmd_j     = cj;
        cmd_k     = ck;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int   accepted;
        int   waited;
        logic [1:0] fpat [4];
        logic [3:0] flen [4];

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_j     = 1'b0;
        cmd_k     = 1'b0;
        cmd_len   = 4'd0;
        chk_en    = 1'b1;
        q_force   = 1'b0;

        // Single command 10/len2, then 10/0, 01/1, 11/3, 00/0 back to back.
        // Inputs are applied before an edge. The expected outputs hold after it.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};

        // ---- reset ----
        step();
        step();
        rst_n = 1'b1;
        check("rst_j", j, 0);
        check("rst_k", k, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_err", err_count, 0);
        check("rst_mismatch", mismatch, 0);

        // ---- table: single command and back-to-back ----
        for (int i = 0; i < 15; i++) begin
            cmd_valid = vecs[i].v;
            cmd_j     = vecs[i].cj;
            cmd_k     = vecs[i].ck;
            cmd_len   = vecs[i].len;
            step();
            check($sformatf("vec%0d_jk", i), {j, k}, {vecs[i].ej, vecs[i].ek});
            check($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
            check($sformatf("vec%0d_ready", i), cmd_ready, vecs[i].eready);
            check($sformatf("vec%0d_mismatch", i), mismatch, 0);
        end
        cmd_valid = 1'b0;
        check("track_err", err_count, 0);

        // ---- FIFO full behind a len=15 command ----
        fpat[0] = 2'b01; flen[0] = 4'd0;
        fpat[1] = 2'b11; flen[1] = 4'd1;
        fpat[2] = 2'b10; flen[2] = 4'd0;
        fpat[3] = 2'b01; flen[3] = 4'd2;
        send(1'b1, 1'b0, 4'd15);
        accepted = 0;
        exp_jk_q.delete();
        for (int n = 0; n < 8; n++) begin
            if (!cmd_ready) break;
            cmd_valid = 1'b1;
            {cmd_j, cmd_k} = fpat[n % 4];
            cmd_len = flen[n % 4];
            step();
            accepted++;
            for (int r = 0; r <= int'(flen[n % 4]); r++) exp_jk_q.push_back(fpat[n % 4]);
        end
        cmd_valid = 1'b0;
        check("full_accepted", accepted, 4);
        check("full_ready_low", cmd_ready, 0);
        check("full_stall_jk", {j, k}, 2'b10);
        waited = 0;
        do begin
            step();
            waited++;
            if ({j, k} == 2'b10) check("full_ready_hold", cmd_ready, 0);
        end while ({j, k} == 2'b10 && waited < 40);
        check("full_stall_cycles", waited, 13);
        check("full_ready_back", cmd_ready, 1);
        while (exp_jk_q.size() > 0) begin
            check("replay_jk", {j, k}, exp_jk_q.pop_front());
            check("replay_busy", busy, 1);
            step();
        end
        check("replay_end_jk", {j, k}, 2'b00);
        check("replay_end_busy", busy, 0);
        check("replay_err", err_count, 0);

        // ---- forced mismatch for 3 cycles ----
        q_force = 1'b1;
        check("mm_not_early", mismatch, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("mm_pulse%0d", c), mismatch, 1);
        end
        q_force = 1'b0;
        step();
        check("mm_clear", mismatch, 0);
        check("mm_err3", err_count, 3);
        check("mm_sat_err3", err_count2, 3);

        // ---- two more: narrow counter stays saturated ----
        q_force = 1'b1;
        step();
        step();
        q_force = 1'b0;
        step();
        check("mm_err5", err_count, 5);
        check("mm_sat_hold", err_count2, 3);

        // ---- chk_en low masks divergence ----
        chk_en  = 1'b0;
        q_force = 1'b1;
        step();
        step();
        check("chk_off_mismatch", mismatch, 0);
        check("chk_off_err", err_count, 5);
        q_force = 1'b0;
        chk_en  = 1'b1;

        // ---- reset mid-drive with two commands queued ----
        send(1'b1, 1'b0, 4'd7);
        send(1'b0, 1'b1, 4'd0);
        send(1'b1, 1'b1, 4'd0);
        step();
        check("middrv_busy", busy, 1);
        check("middrv_jk", {j, k}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("async_rst_jk", {j, k}, 2'b00);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", cmd_ready, 1);
        check("async_rst_err", err_count, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            check("no_replay_jk", {j, k}, 2'b00);
            check("no_replay_busy", busy, 0);
        end
        check("post_rst_err", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
